// File: rtl/sccb_slave.sv
// sccb_slave -- SCCB (camera-control bus) register-access slave.
//
// Purpose:
//   Listens on an oversampled SCCB bus and turns 3-phase write cycles
//   (ID / sub-address / data) into one-cycle register write strobes.
//   It answers 2-phase read cycles (ID / read data) by shifting out the
//   register value at reg_addr. A 2-phase write (ID / sub-address, STOP)
//   only updates reg_addr, which sets up the address for a following read.
//
// Ports:
//   clk        system clock; all logic runs on its rising edge
//   rst        asynchronous active-high reset
//   scl        SCCB clock as seen on the bus
//   sda_in     SCCB data as seen on the bus
//   sda_oe     open-drain drive; 1 pulls SDA low, 0 releases it
//   reg_addr   latched sub-address; persists until the next sub-address phase
//   reg_wdata  received write data
//   reg_we     one-cycle write strobe
//   reg_rdata  combinational register value at reg_addr
//   busy       high from START to the matching STOP
//   done       one-cycle pulse when a write or read cycle completes
//
// Configuration:
//   SCCB_SLAVE_ACK_EN  when defined, the slave pulls SDA low during the ninth
//                      (acknowledge) bit of a matching transfer, as on I2C.
//                      When undefined, the ninth bit is left as the SCCB
//                      don't-care bit.

module sccb_slave #(
  parameter logic [7:0] DEV_ID = 8'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_DEV_ID   = 4'd1;
  localparam logic [3:0] ST_DEV_ACK  = 4'd2;
  localparam logic [3:0] ST_SUB_ADDR = 4'd3;
  localparam logic [3:0] ST_SUB_ACK  = 4'd4;
  localparam logic [3:0] ST_WR_DATA  = 4'd5;
  localparam logic [3:0] ST_WR_ACK   = 4'd6;
  localparam logic [3:0] ST_RD_DATA  = 4'd7;
  localparam logic [3:0] ST_RD_NA    = 4'd8;
  localparam logic [3:0] ST_IGNORE   = 4'd9;

`ifdef SCCB_SLAVE_ACK_EN
  localparam logic ACK_DRIVE = 1'b1;
`else
  localparam logic ACK_DRIVE = 1'b0;
`endif

  logic       sclMeta_q, sclSync_q, sclDly_q;
  logic       sdaMeta_q, sdaSync_q, sdaDly_q;
  logic       sclRise, sclFall, startDet, stopDet;
  logic [7:0] rxByte;

  logic [3:0] state_q, state_d;
  logic [3:0] bitCnt_q, bitCnt_d;
  logic [7:0] shift_q, shift_d;
  logic       isRead_q, isRead_d;
  logic       sdaOe_q, sdaOe_d;
  logic [7:0] regAddr_q, regAddr_d;
  logic [7:0] regWdata_q, regWdata_d;
  logic       regWe_q, regWe_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

  // Two-flop synchronizers for both bus lines plus one extra stage so edges
  // can be seen. Everything resets to the idle-high bus level so that leaving
  // reset on an idle bus produces no false START or STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclMeta_q <= 1'b1;
      sclSync_q <= 1'b1;
      sclDly_q  <= 1'b1;
      sdaMeta_q <= 1'b1;
      sdaSync_q <= 1'b1;
      sdaDly_q  <= 1'b1;
    end else begin
      sclMeta_q <= scl;
      sclSync_q <= sclMeta_q;
      sclDly_q  <= sclSync_q;
      sdaMeta_q <= sda_in;
      sdaSync_q <= sdaMeta_q;
      sdaDly_q  <= sdaSync_q;
    end
  end

  // START/STOP need SCL high in both compared samples, so an SDA change that
  // lands in the same cycle as an SCL edge is never taken for a bus condition.
  assign sclRise  =  sclSync_q & ~sclDly_q;
  assign sclFall  = ~sclSync_q &  sclDly_q;
  assign startDet =  sclSync_q &  sclDly_q &  sdaDly_q & ~sdaSync_q;
  assign stopDet  =  sclSync_q &  sclDly_q & ~sdaDly_q &  sdaSync_q;
  assign rxByte   = {shift_q[6:0], sdaSync_q};

  // Protocol sequencer. Received bits are taken on the SCL rise. Anything the
  // slave drives on SDA changes only on the SCL fall, so the line stays still
  // while SCL is high. In acknowledge states, bitCnt only marks whether the
  // ninth clock has risen yet. The first fall drives the ACK level and the
  // second fall ends the bit.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    isRead_d   = isRead_q;
    sdaOe_d    = sdaOe_q;
    regAddr_d  = regAddr_q;
    regWdata_d = regWdata_q;
    regWe_d    = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;

    if (stopDet) begin
      state_d  = ST_IDLE;
      bitCnt_d = 4'd0;
      sdaOe_d  = 1'b0;
      busy_d   = 1'b0;
    end else if (startDet) begin
      state_d  = ST_DEV_ID;
      bitCnt_d = 4'd0;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        ST_DEV_ID, ST_SUB_ADDR, ST_WR_DATA: begin
          if (sclRise) begin
            shift_d  = rxByte;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd7) begin
              bitCnt_d = 4'd0;
              case (state_q)
                ST_DEV_ID: begin
                  if (rxByte == DEV_ID) begin
                    isRead_d = 1'b0;
                    state_d  = ST_DEV_ACK;
                  end else if (rxByte == (DEV_ID | 8'h01)) begin
                    isRead_d = 1'b1;
                    state_d  = ST_DEV_ACK;
                  end else begin
                    state_d  = ST_IGNORE;
                  end
                end
                ST_SUB_ADDR: begin
                  regAddr_d = rxByte;
                  state_d   = ST_SUB_ACK;
                end
                default: begin
                  regWdata_d = rxByte;
                  regWe_d    = 1'b1;
                  done_d     = 1'b1;
                  state_d    = ST_WR_ACK;
                end
              endcase
            end
          end
        end

        ST_DEV_ACK, ST_SUB_ACK, ST_WR_ACK: begin
          if (sclRise) begin
            bitCnt_d = 4'd1;
          end else if (sclFall) begin
            if (bitCnt_q == 4'd0) begin
              sdaOe_d = ACK_DRIVE;
            end else begin
              bitCnt_d = 4'd0;
              sdaOe_d  = 1'b0;
              case (state_q)
                ST_DEV_ACK: begin
                  if (isRead_q) begin
                    // The first read bit goes out on the same fall that ends the ACK bit.
                    shift_d = reg_rdata;
                    sdaOe_d = ~reg_rdata[7];
                    state_d = ST_RD_DATA;
                  end else begin
                    state_d = ST_SUB_ADDR;
                  end
                end
                ST_SUB_ACK: state_d = ST_WR_DATA;
                default:    state_d = ST_IGNORE;
              endcase
            end
          end
        end

        ST_RD_DATA: begin
          if (sclRise) begin
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall) begin
            if (bitCnt_q == 4'd8) begin
              bitCnt_d = 4'd0;
              sdaOe_d  = 1'b0;
              done_d   = 1'b1;
              state_d  = ST_RD_NA;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              sdaOe_d = ~shift_q[6];
            end
          end
        end

        ST_RD_NA: begin
          if (sclRise) begin
            state_d = ST_IGNORE;
          end
        end

        ST_IGNORE: begin
          sdaOe_d = 1'b0;
        end

        ST_IDLE: begin
          sdaOe_d = 1'b0;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bitCnt_q   <= 4'd0;
      shift_q    <= 8'h00;
      isRead_q   <= 1'b0;
      sdaOe_q    <= 1'b0;
      regAddr_q  <= 8'h00;
      regWdata_q <= 8'h00;
      regWe_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      isRead_q   <= isRead_d;
      sdaOe_q    <= sdaOe_d;
      regAddr_q  <= regAddr_d;
      regWdata_q <= regWdata_d;
      regWe_q    <= regWe_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_oe    = sdaOe_q;
  assign reg_addr  = regAddr_q;
  assign reg_wdata = regWdata_q;
  assign reg_we    = regWe_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule
